uart_tx_arbiter: RTL and testbench

- Shares the single UART transmitter between two result producers: the ALU (16-bit result, sent as two bytes) and the register file (8-bit read data, sent as one byte).
- Arbitrates round-robin, buffers the granted word, and feeds the transmitter one byte at a time using its DATA_VALID/Busy handshake.
- Sits between the system controller datapath and UART_TX_TOP, in the same clock domain as the transmitter.

---
 rtl/uart_arb_pkg.sv | 19 +
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/rr_arbiter_2.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter: FSM encoding,
// one-hot grant codes and per-source byte counts.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    GAP     = 3'd4
  } arb_state_e;

  localparam logic [1:0] GRANT_ALU = 2'b01;
  localparam logic [1:0] GRANT_RF  = 2'b10;

  localparam logic [1:0] ALU_BYTES = 2'd2;
  localparam logic [1:0] RF_BYTES  = 2'd1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the two result producers, the arbiter and UART_TX_TOP,
// plus the arbiter FSM state exposed for observation.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
) ();

  // Producers raise *_VLD with stable data and hold both until the matching
  // *_RDY pulse (one cycle) is seen; the transmitter is fed one byte per
  // TX_DATA_VALID strobe, only while TX_BUSY is low.
  logic [ALU_WIDTH-1:0]       ALU_OUT;
  logic                       ALU_VLD;
  logic                       ALU_RDY;
  logic [DATA_WIDTH-1:0]      RF_RD_DATA;
  logic                       RF_RD_VLD;
  logic                       RF_RDY;
  logic                       TX_BUSY;
  logic [DATA_WIDTH-1:0]      TX_P_DATA;
  logic                       TX_DATA_VALID;
  logic                       ARB_BUSY;
  logic [1:0]                 GRANT;
  uart_arb_pkg::arb_state_e   STATE;

  modport slave (
    input  ALU_OUT, ALU_VLD, RF_RD_DATA, RF_RD_VLD, TX_BUSY,
    output ALU_RDY, RF_RDY, TX_P_DATA, TX_DATA_VALID, ARB_BUSY, GRANT, STATE
  );

  modport master (
    output ALU_OUT, ALU_VLD, RF_RD_DATA, RF_RD_VLD, TX_BUSY,
    input  ALU_RDY, RF_RDY, TX_P_DATA, TX_DATA_VALID, ARB_BUSY, GRANT, STATE
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; grant is combinational from req and the
// priority pointer, which moves only when the grant is taken (advance_i).
module rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  // prio_rf_q=1 means RF wins the next tie; reset favours the ALU.
  logic prio_rf_q;

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = prio_rf_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_rf_q <= 1'b0;
    end else if (advance_i && (grant_o != 2'b00)) begin
      prio_rf_q <= grant_o[0];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter between the ALU (two bytes,
// low first) and the register file (one byte). UART_ARB_GAP_EN adds GAP.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ALU_WIDTH  = 16
`ifdef UART_ARB_GAP_EN
  , parameter int GAP_CYCLES = 2
`endif
) (
  input logic              CLK,
  input logic              RST,
  uart_tx_arbiter_if.slave bus
);

  arb_state_e             state_q, state_d;
  logic [ALU_WIDTH-1:0]   buf_q, buf_d;
  logic [1:0]             cnt_q, cnt_d;
  logic [1:0]             grant_q, grant_d;
  logic [DATA_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                   tx_dv_q, tx_dv_d;
  logic                   alu_rdy_q, alu_rdy_d;
  logic                   rf_rdy_q, rf_rdy_d;
  logic [1:0]             arb_grant;
  logic                   advance;

`ifdef UART_ARB_GAP_EN
  localparam int GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GapW-1:0] gap_q, gap_d;
`endif

  rr_arbiter_2 u_rr (
    .clk_i     (CLK),
    .rst_i     (RST),
    .req_i     ({bus.RF_RD_VLD, bus.ALU_VLD}),
    .advance_i (advance),
    .grant_o   (arb_grant)
  );

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    tx_dv_d   = 1'b0;
    alu_rdy_d = 1'b0;
    rf_rdy_d  = 1'b0;
    advance   = 1'b0;
`ifdef UART_ARB_GAP_EN
    gap_d     = gap_q;
`endif
    case (state_q)
      IDLE: begin
        if (arb_grant != 2'b00) begin
          advance = 1'b1;
          grant_d = arb_grant;
          state_d = LOAD;
          if (arb_grant == GRANT_ALU) begin
            buf_d     = bus.ALU_OUT;
            cnt_d     = ALU_BYTES;
            alu_rdy_d = 1'b1;
          end else begin
            buf_d    = ALU_WIDTH'(bus.RF_RD_DATA);
            cnt_d    = RF_BYTES;
            rf_rdy_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (!bus.TX_BUSY) begin
          tx_dv_d   = 1'b1;
          tx_data_d = buf_q[DATA_WIDTH-1:0];
          state_d   = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (bus.TX_BUSY) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!bus.TX_BUSY) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_d != 2'd0) begin
            // Next byte sits in the low lane after shifting.
            buf_d   = buf_q >> DATA_WIDTH;
            state_d = LOAD;
          end else begin
            grant_d = 2'b00;
`ifdef UART_ARB_GAP_EN
            gap_d   = '0;
            state_d = GAP;
`else
            state_d = IDLE;
`endif
          end
        end
      end
`ifdef UART_ARB_GAP_EN
      GAP: begin
        if (gap_q == GapW'(GAP_CYCLES - 1)) state_d = IDLE;
        else                                gap_d   = gap_q + 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      tx_data_q <= '0;
      tx_dv_q   <= 1'b0;
      alu_rdy_q <= 1'b0;
      rf_rdy_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      tx_dv_q   <= tx_dv_d;
      alu_rdy_q <= alu_rdy_d;
      rf_rdy_q  <= rf_rdy_d;
    end
  end

`ifdef UART_ARB_GAP_EN
  always_ff @(posedge CLK) begin
    if (RST) gap_q <= '0;
    else     gap_q <= gap_d;
  end
`endif

  assign bus.ALU_RDY       = alu_rdy_q;
  assign bus.RF_RDY        = rf_rdy_q;
  assign bus.TX_P_DATA     = tx_data_q;
  assign bus.TX_DATA_VALID = tx_dv_q;
  assign bus.ARB_BUSY      = (state_q != IDLE);
  assign bus.GRANT         = grant_q;
  assign bus.STATE         = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: TX busy model, requester drivers and a byte/grant
// scoreboard; build with UART_ARB_GAP_EN to exercise the inter-frame gap.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int DW             = 8;
  localparam int AW             = 16;
  localparam int GAP_CYCLES     = 2;
  localparam int TX_BUSY_CYCLES = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) bus ();

  uart_tx_arbiter #(.DATA_WIDTH(DW), .ALU_WIDTH(AW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int n_checks    = 0;
  int n_fail      = 0;
  int strobe_cnt  = 0;
  int alu_rdy_cnt = 0;
  int rf_rdy_cnt  = 0;
  int busy_cnt    = 0;
  logic force_busy = 1'b0;

  logic [DW-1:0] exp_q[$];
  logic [1:0]    own_q[$];

  // ---------------- TX model, requester release, scoreboard ----------------
  initial begin
    logic [DW-1:0] exp_b;
    logic [1:0]    exp_g;
    bus.TX_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_cnt = 0;
      end else begin
        if (bus.TX_DATA_VALID === 1'b1) begin
          n_checks++;
          if (bus.TX_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL strobe_while_busy: TX_BUSY=%b, required 0", bus.TX_BUSY);
          end
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: byte %h, required no strobe", bus.TX_P_DATA);
          end else begin
            exp_b = exp_q.pop_front();
            if (bus.TX_P_DATA !== exp_b) begin
              n_fail++;
              $display("FAIL tx_byte: got %h, required %h", bus.TX_P_DATA, exp_b);
            end
          end
          strobe_cnt++;
          busy_cnt = TX_BUSY_CYCLES;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
        if (bus.ALU_RDY === 1'b1 || bus.RF_RDY === 1'b1) begin
          n_checks++;
          if (own_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_grant: rdy=%b%b, required none", bus.RF_RDY, bus.ALU_RDY);
          end else begin
            exp_g = own_q.pop_front();
            if ({bus.RF_RDY, bus.ALU_RDY} !== exp_g || bus.GRANT !== exp_g) begin
              n_fail++;
              $display("FAIL grant_owner: rdy=%b%b grant=%b, required %b",
                       bus.RF_RDY, bus.ALU_RDY, bus.GRANT, exp_g);
            end
          end
          if (bus.ALU_RDY === 1'b1) begin alu_rdy_cnt++; bus.ALU_VLD = 1'b0; end
          if (bus.RF_RDY === 1'b1) begin rf_rdy_cnt++; bus.RF_RD_VLD = 1'b0; end
        end
      end
      bus.TX_BUSY = force_busy | (busy_cnt > 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    force_busy = 1'b0;
    bus.ALU_VLD = 1'b0;
    bus.RF_RD_VLD = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    own_q.delete();
    rst = 1'b0;
  endtask

  task automatic send_rf(input logic [DW-1:0] d);
    @(negedge clk);
    bus.RF_RD_DATA = d;
    bus.RF_RD_VLD  = 1'b1;
    exp_q.push_back(d);
    own_q.push_back(GRANT_RF);
  endtask

  task automatic send_alu(input logic [AW-1:0] d);
    @(negedge clk);
    bus.ALU_OUT = d;
    bus.ALU_VLD = 1'b1;
    exp_q.push_back(d[7:0]);
    exp_q.push_back(d[15:8]);
    own_q.push_back(GRANT_ALU);
  endtask

  task automatic wait_drop(input int budget);
    int n = 0;
    while ((bus.ALU_VLD || bus.RF_RD_VLD) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL timeout_rdy: waited %0d cycles, required RDY within %0d", n, budget);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || own_q.size() != 0 || bus.ALU_VLD || bus.RF_RD_VLD ||
            bus.ARB_BUSY !== 1'b0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_fail++;
      $display("FAIL timeout_idle: %0d bytes still pending, required 0", exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    #1;
    n_checks++;
    if (bus.STATE !== IDLE || bus.ARB_BUSY !== 1'b0 || bus.GRANT !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_state: state=%0d busy=%b grant=%b, required 0 0 00",
               bus.STATE, bus.ARB_BUSY, bus.GRANT);
    end
    n_checks++;
    if (bus.TX_DATA_VALID !== 1'b0 || bus.TX_P_DATA !== 8'h00 ||
        bus.ALU_RDY !== 1'b0 || bus.RF_RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: dv=%b data=%h ardy=%b rrdy=%b, required all 0",
               bus.TX_DATA_VALID, bus.TX_P_DATA, bus.ALU_RDY, bus.RF_RDY);
    end
  endtask

  task automatic test_rf_only();
    int s0 = strobe_cnt;
    int r0 = rf_rdy_cnt;
    send_rf(8'h93);
    @(negedge clk); #1;
    n_checks++;
    if (bus.RF_RDY !== 1'b1 || bus.GRANT !== GRANT_RF) begin
      n_fail++;
      $display("FAIL rf_rdy_latency: rdy=%b grant=%b, required 1 10", bus.RF_RDY, bus.GRANT);
    end
    @(negedge clk); #1;
    n_checks++;
    if (bus.TX_DATA_VALID !== 1'b1 || bus.TX_P_DATA !== 8'h93) begin
      n_fail++;
      $display("FAIL rf_strobe_latency: dv=%b data=%h, required 1 93",
               bus.TX_DATA_VALID, bus.TX_P_DATA);
    end
    wait_idle(200);
    n_checks++;
    if (strobe_cnt - s0 != 1 || rf_rdy_cnt - r0 != 1 || bus.GRANT !== 2'b00) begin
      n_fail++;
      $display("FAIL rf_counts: strobes=%0d rdys=%0d grant=%b, required 1 1 00",
               strobe_cnt - s0, rf_rdy_cnt - r0, bus.GRANT);
    end
  endtask

  task automatic test_alu_only();
    int s0 = strobe_cnt;
    int a0 = alu_rdy_cnt;
    send_alu(16'hAA55);
    wait_idle(300);
    n_checks++;
    if (strobe_cnt - s0 != 2 || alu_rdy_cnt - a0 != 1) begin
      n_fail++;
      $display("FAIL alu_counts: strobes=%0d rdys=%0d, required 2 1",
               strobe_cnt - s0, alu_rdy_cnt - a0);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int round = 0; round < 2; round++) begin
      @(negedge clk);
      bus.ALU_OUT    = 16'h1234;
      bus.RF_RD_DATA = 8'h77;
      bus.ALU_VLD    = 1'b1;
      bus.RF_RD_VLD  = 1'b1;
      exp_q.push_back(8'h34);
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h77);
      own_q.push_back(GRANT_ALU);
      own_q.push_back(GRANT_RF);
      wait_drop(300);
    end
    wait_idle(400);
  endtask

  task automatic test_busy_hold();
    int s0;
    @(posedge clk); #1;
    force_busy = 1'b1;
    send_rf(8'h3C);
    wait_drop(20);
    s0 = strobe_cnt;
    repeat (5) @(negedge clk);
    #1;
    n_checks++;
    if (strobe_cnt != s0 || bus.STATE !== LOAD) begin
      n_fail++;
      $display("FAIL busy_hold: strobes=%0d state=%0d, required 0 LOAD", strobe_cnt - s0, bus.STATE);
    end
    @(posedge clk); #1;
    force_busy = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (bus.TX_DATA_VALID !== 1'b1 || bus.TX_P_DATA !== 8'h3C || strobe_cnt - s0 != 1) begin
      n_fail++;
      $display("FAIL busy_release: dv=%b data=%h strobes=%0d, required 1 3c 1",
               bus.TX_DATA_VALID, bus.TX_P_DATA, strobe_cnt - s0);
    end
    wait_idle(200);
  endtask

  task automatic test_reset_mid();
    int s0;
    int n = 0;
    do_reset();
    s0 = strobe_cnt;
    @(negedge clk);
    bus.ALU_OUT = 16'hAA55;
    bus.ALU_VLD = 1'b1;
    exp_q.push_back(8'h55);
    own_q.push_back(GRANT_ALU);
    while (bus.STATE !== WAIT_LO && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL timeout_wait_lo: state=%0d, required WAIT_LO", bus.STATE);
    end
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++;
    if (bus.STATE !== IDLE || bus.ARB_BUSY !== 1'b0 || bus.GRANT !== 2'b00 ||
        bus.TX_DATA_VALID !== 1'b0 || bus.TX_P_DATA !== 8'h00 ||
        bus.ALU_RDY !== 1'b0 || bus.RF_RDY !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: state=%0d busy=%b grant=%b dv=%b data=%h, required all 0",
               bus.STATE, bus.ARB_BUSY, bus.GRANT, bus.TX_DATA_VALID, bus.TX_P_DATA);
    end
    rst = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    n_checks++;
    if (strobe_cnt - s0 != 1 || bus.ARB_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_abandon: strobes=%0d busy=%b, required 1 0",
               strobe_cnt - s0, bus.ARB_BUSY);
    end
  endtask

  task automatic test_back_to_back();
    int gaps = 0;
    int n = 0;
    int exp_gaps;
`ifdef UART_ARB_GAP_EN
    exp_gaps = GAP_CYCLES;
`else
    exp_gaps = 0;
`endif
    send_rf(8'h11);
    wait_drop(20);
    send_rf(8'h22);
    while (n < 100) begin
      @(negedge clk); #1;
      n++;
      if (bus.RF_RDY === 1'b1) break;
      if (bus.ARB_BUSY === 1'b1 && bus.GRANT === 2'b00) gaps++;
    end
    n_checks++;
    if (n >= 100 || gaps != exp_gaps) begin
      n_fail++;
      $display("FAIL frame_gap: gap cycles=%0d waited=%0d, required %0d", gaps, n, exp_gaps);
    end
    wait_idle(200);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.ALU_OUT    = '0;
    bus.ALU_VLD    = 1'b0;
    bus.RF_RD_DATA = '0;
    bus.RF_RD_VLD  = 1'b0;
    test_reset();
    test_rf_only();
    test_alu_only();
    test_round_robin();
    test_busy_hold();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0 || own_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: bytes=%0d grants=%0d left, required 0 0",
               exp_q.size(), own_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
